// File: rtl/freq_avg_sequencer_if.sv
// -----------------------------------------------------------------------------
// freq_avg_sequencer_if
//
// Register-file bus between the averaging sequencer and the sample reg_file.
// The write port is driven by the sequencer whenever a new measurement is
// accepted. The read port is combinational: data_r must reflect the entry at
// address_r in the same cycle.
//
// Signals:
//   we         sequencer -> reg_file   write enable
//   address_w  sequencer -> reg_file   write address (ring write pointer)
//   data_w     sequencer -> reg_file   write data (measurement value)
//   address_r  sequencer -> reg_file   read address
//   data_r     reg_file  -> sequencer  read data, same cycle as address_r
//
// Modports:
//   master  sequencer side
//   slave   reg_file side
// -----------------------------------------------------------------------------
interface freq_avg_sequencer_if #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 25
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] address_w;
    logic [DATA_WIDTH-1:0] data_w;
    logic [ADDR_WIDTH-1:0] address_r;
    logic [DATA_WIDTH-1:0] data_r;

    modport master (
        output we,
        output address_w,
        output data_w,
        output address_r,
        input  data_r
    );

    modport slave (
        input  we,
        input  address_w,
        input  data_w,
        input  address_r,
        output data_r
    );
endinterface

// File: rtl/freq_avg_sequencer.sv
// -----------------------------------------------------------------------------
// freq_avg_sequencer
//
// Sequences the sample buffer and the averaging path of the frequency meter.
// Every completed period measurement is written into a ring of 2^ADDR_WIDTH
// reg_file entries. On each averaging tick the valid entries are read back,
// summed, and divided by the entry count with a bit-serial restoring divider.
// The result is published on avg with a one-cycle avg_valid pulse.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   reset_n     asynchronous active-low reset
//   enable      run control; low forces IDLE and clears the buffer state
//   meas_done   one-cycle pulse, meas_value holds a new sample
//   meas_value  sample from the measurement unit
//   tick        one-cycle averaging-period pulse
//   rf          reg_file bus (master side): we/address_w/data_w/address_r/data_r
//   avg         last published average (registered)
//   avg_valid   one-cycle pulse while avg has just been updated
//   fill_count  number of valid buffer entries, 0..DEPTH
//   stale       no sample seen for TIMEOUT_TICKS consecutive ticks
//   busy        high while an average is in flight (ACCUM, DIVIDE, PUBLISH)
//
// Latency from the tick cycle T: avg_valid in T+1+n+W for n > 0 entries,
// T+1 for an empty buffer, where W = DATA_WIDTH+ADDR_WIDTH.
// -----------------------------------------------------------------------------
module freq_avg_sequencer #(
    parameter int ADDR_WIDTH    = 2,
    parameter int DATA_WIDTH    = 25,
    parameter int TIMEOUT_TICKS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  meas_done,
    input  logic [DATA_WIDTH-1:0] meas_value,
    input  logic                  tick,
    freq_avg_sequencer_if.master  rf,
    output logic [DATA_WIDTH-1:0] avg,
    output logic                  avg_valid,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  stale,
    output logic                  busy
);

    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int ACC_W     = DATA_WIDTH + ADDR_WIDTH;   // also the divide length
    localparam int CNT_W     = $clog2(TIMEOUT_TICKS + 1);
    localparam int DIV_CNT_W = $clog2(ACC_W);
    localparam int REM_W     = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCUM,
        S_DIVIDE,
        S_PUBLISH
    } state_t;

    state_t                 state_q, state_d;

    // Buffer bookkeeping
    logic [ADDR_WIDTH-1:0]  wptr_q;
    logic [ADDR_WIDTH:0]    fill_q;
    logic [CNT_W-1:0]       stale_cnt_q;

    // Averaging datapath
    logic [ADDR_WIDTH:0]    n_q;          // entry count snapshot for this average
    logic [ACC_W-1:0]       acc_q;        // sum, then dividend/quotient shift register
    logic [REM_W-1:0]       rem_q;        // divider partial remainder, always < n_q
    logic [DIV_CNT_W-1:0]   div_cnt_q;
    logic [ADDR_WIDTH-1:0]  rd_addr_q;
    logic [DATA_WIDTH-1:0]  avg_q;

    logic                   write_en;
    logic                   stale_hit;
    logic [ADDR_WIDTH:0]    n_eff;
    logic                   last_read;
    logic [ACC_W-1:0]       acc_sum;
    logic [REM_W:0]         div_shifted;
    logic                   div_ge;
    logic [REM_W-1:0]       rem_nxt;
    logic [ACC_W-1:0]       quo_nxt;

    // -------------------------------------------------------------------------
    // Write path and stale detection
    // -------------------------------------------------------------------------
    assign write_en = meas_done & enable;

    // This tick completes the timeout run. A sample in the same cycle clears
    // the counter instead, so a hit never coincides with a write.
    assign stale_hit = enable & tick & ~meas_done &
                       (stale_cnt_q >= CNT_W'(TIMEOUT_TICKS - 1));

    // Entry count a tick in this cycle would average over: the pre-edge
    // fill level, or zero when this very tick declares the buffer stale.
    assign n_eff = stale_hit ? '0 : fill_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q      <= '0;
            fill_q      <= '0;
            stale_cnt_q <= '0;
        end else if (!enable) begin
            wptr_q      <= '0;
            fill_q      <= '0;
            stale_cnt_q <= '0;
        end else begin
            if (write_en) begin
                wptr_q      <= wptr_q + ADDR_WIDTH'(1);
                stale_cnt_q <= '0;
                if (fill_q != (ADDR_WIDTH + 1)'(DEPTH)) begin
                    fill_q <= fill_q + (ADDR_WIDTH + 1)'(1);
                end
            end else if (tick) begin
                if (stale_cnt_q != CNT_W'(TIMEOUT_TICKS)) begin
                    stale_cnt_q <= stale_cnt_q + CNT_W'(1);
                end
                if (stale_hit) begin
                    wptr_q <= '0;
                    fill_q <= '0;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Accumulate and restoring-divide step logic
    // -------------------------------------------------------------------------
    assign acc_sum   = acc_q + ACC_W'(rf.data_r);
    assign last_read = (({1'b0, rd_addr_q} + (ADDR_WIDTH + 1)'(1)) == n_q);

    // One quotient bit per cycle: shift the next dividend bit into the
    // remainder, subtract n when it fits, and shift the outcome into acc_q.
    assign div_shifted = {rem_q, acc_q[ACC_W-1]};
    assign div_ge      = (div_shifted >= {1'b0, n_q});
    assign rem_nxt     = div_ge ? REM_W'(div_shifted - {1'b0, n_q})
                                : REM_W'(div_shifted);
    assign quo_nxt     = {acc_q[ACC_W-2:0], div_ge};

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tick) state_d = (n_eff == '0) ? S_PUBLISH : S_ACCUM;
            end
            S_ACCUM: begin
                if (last_read) state_d = S_DIVIDE;
            end
            S_DIVIDE: begin
                if (div_cnt_q == DIV_CNT_W'(ACC_W - 1)) state_d = S_PUBLISH;
            end
            S_PUBLISH: begin
                state_d = S_WAIT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Run control overrides everything; an in-flight average is dropped.
        if (!enable) state_d = S_IDLE;
    end

    // -------------------------------------------------------------------------
    // Datapath registers, keyed on the transition being taken so that an
    // enable drop never loads avg.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_q       <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            div_cnt_q <= '0;
            rd_addr_q <= '0;
            avg_q     <= '0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (state_d == S_ACCUM) begin
                        n_q       <= n_eff;
                        acc_q     <= '0;
                        rem_q     <= '0;
                        div_cnt_q <= '0;
                        rd_addr_q <= '0;
                    end else if (state_d == S_PUBLISH) begin
                        avg_q <= '0;
                    end
                end
                S_ACCUM: begin
                    acc_q     <= acc_sum;
                    rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
                end
                S_DIVIDE: begin
                    acc_q     <= quo_nxt;
                    rem_q     <= rem_nxt;
                    div_cnt_q <= div_cnt_q + DIV_CNT_W'(1);
                    if (state_d == S_PUBLISH) begin
                        avg_q <= quo_nxt[DATA_WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rf.we        = write_en;
    assign rf.address_w = wptr_q;
    assign rf.data_w    = meas_value;
    assign rf.address_r = rd_addr_q;

    assign avg        = avg_q;
    assign avg_valid  = (state_q == S_PUBLISH);
    assign busy       = (state_q == S_ACCUM) || (state_q == S_DIVIDE) ||
                        (state_q == S_PUBLISH);
    assign fill_count = fill_q;
    assign stale      = (stale_cnt_q == CNT_W'(TIMEOUT_TICKS));

endmodule

// File: doc/freq_avg_sequencer.md
Name: freq_avg_sequencer

Overview:
- Controller that sequences the sample buffer and averaging path of the frequency meter.
- Writes each completed period measurement into a ring of 2^ADDR_WIDTH register-file entries.
- On every averaging tick, reads back the valid entries, accumulates them and divides by the entry count using a sequential restoring divider.
- Publishes the average with a one-cycle valid pulse. Sits between the period-measurement unit, the sample reg_file and the result holder / BCD display path.

Parameters:
ADDR_WIDTH, 2, log2 of buffer depth; DEPTH = 2^ADDR_WIDTH
DATA_WIDTH, 25, width of one measurement and of the average
TIMEOUT_TICKS, 4, consecutive ticks with no measurement before the buffer is declared stale

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
enable  input  1  run control; low forces IDLE
meas_done  input  1  one-cycle pulse: meas_value holds a new sample
meas_value  input  DATA_WIDTH  sample from the measurement unit
tick  input  1  one-cycle averaging-period pulse
we  output  1  reg_file write enable
address_w  output  ADDR_WIDTH  reg_file write address
data_w  output  DATA_WIDTH  reg_file write data
address_r  output  ADDR_WIDTH  reg_file read address (combinational read)
data_r  input  DATA_WIDTH  reg_file read data, same cycle as address_r
avg  output  DATA_WIDTH  last published average (registered)
avg_valid  output  1  one-cycle pulse when avg updates
fill_count  output  ADDR_WIDTH+1  valid entries, 0..DEPTH
stale  output  1  no sample for TIMEOUT_TICKS ticks
busy  output  1  high in ACCUM, DIVIDE and PUBLISH

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (reset_n).
- Reset values:
  - State IDLE.
  - avg, avg_valid, fill_count, stale, busy, address_w, address_r and the accumulator all 0.
  - stale counter 0.
- Write path (combinational):
  - we = meas_done & enable; data_w = meas_value.
  - address_w is the write pointer. It increments mod DEPTH after each write (wraps 3->0 at default).
  - fill_count increments per write and saturates at DEPTH.
  - Writes are accepted in every non-IDLE state, including during averaging.
- States:
  - IDLE: enable low. Write pointer, fill_count and stale counter are cleared; tick is ignored. enable high -> WAIT.
  - WAIT:
    - On tick, snapshot n = fill_count as it stood before that edge. A sample written in the same cycle is counted in fill_count but excluded from n.
    - n == 0 -> PUBLISH with result 0.
    - Otherwise clear the accumulator, set address_r = 0 and go to ACCUM.
  - ACCUM: each cycle, acc += data_r and address_r increments. Runs exactly n cycles (entries 0..n-1), then -> DIVIDE. acc is DATA_WIDTH+ADDR_WIDTH bits wide and cannot overflow.
  - DIVIDE: restoring division acc / n, one quotient bit per cycle, W = DATA_WIDTH+ADDR_WIDTH cycles (27 at default). Truncating division. The quotient is guaranteed to fit in DATA_WIDTH bits, and the low DATA_WIDTH bits are kept. Then -> PUBLISH.
  - PUBLISH: avg is loaded at the entry edge and avg_valid is high for this single cycle. Then -> WAIT.
- Latency, from the tick cycle T:
  - n > 0: avg_valid in cycle T+1+n+W.
  - n == 0: avg_valid in cycle T+1.
- Tick outside WAIT is ignored (dropped, not queued).
- Stale logic:
  - The counter increments on each tick with no meas_done since the previous tick, and saturates at TIMEOUT_TICKS.
  - On reaching TIMEOUT_TICKS: stale = 1, fill_count is cleared and the write pointer reset to 0. That same tick, if in WAIT, uses n = 0.
  - Any meas_done clears the counter and stale.
- enable deasserted mid-operation: -> IDLE at the next edge, the average is abandoned, and avg keeps its previous value.
- reset_n asserted in any state: immediate return to reset values.

Test Plan:
- Reset: assert reset_n=0 mid-DIVIDE -> avg=0, avg_valid=0, fill_count=0, busy=0 immediately; after release the FSM is in IDLE.
- Full buffer: samples 100,200,300,400, then tick at cycle T -> avg=250, avg_valid only in T+32, busy high T+1..T+32.
- Partial buffer: samples 10,20,31, then tick -> n=3, avg=20 (61/3 truncated), avg_valid at T+31.
- Empty buffer: enable high, tick without samples -> avg=0, avg_valid at T+1, busy high for one cycle.
- Wrap and overlap:
  - Samples 1..6 give ram {5,6,3,4} and address_w=2 -> average 4.
  - meas_done coincident with tick -> the sample is written, fill_count rises, and that tick's n excludes the sample.
  - Tick during ACCUM -> ignored.
- Stale and enable:
  - 4 consecutive ticks without meas_done -> stale=1, fill_count=0, the 4th tick publishes 0; next meas_done -> stale=0.
  - Drop enable during ACCUM -> IDLE, no avg_valid, avg unchanged.
